status_led_driver: RTL
======================

// Module: status_led_driver
// PURPOSE
// Parametrised multi-channel board-status indicator for PL LEDs/PMOD debug pins. Replaces ad-hoc
// free-running counter taps with per-channel selectable modes: static level, shared heartbeat
// blink, event pulse-stretch and blink-code (N flashes then gap). One prescaled ms tick is shared
// by all channels; sits beside the block-design wrapper, driven by reset/lock/link status.
// PARAMETERS
// N_CH        2            number of LED channels
// CLK_HZ      125000000    clk frequency in Hz
// TICK_HZ     1000         tick rate; DIV = CLK_HZ/TICK_HZ, elaboration error if DIV < 2
// BLINK_T     250          heartbeat half-period, ticks
// STRETCH_T   50           pulse-stretch on-time, ticks
// CODE_ON_T   200          blink-code on-time per flash, ticks
// CODE_OFF_T  200          blink-code off-time between flashes, ticks
// CODE_GAP_T  1000         blink-code gap after last flash, ticks
// CODE_W      4            width of per-channel flash count
// ACTIVE_LOW  0            1: led_o inverted at output register
// PORTS
// clk      in   1           single clock
// rst      in   1           synchronous active-high reset
// mode     in   2*N_CH      per-channel mode, ch i = mode[2i+1:2i]
// level    in   N_CH        static-mode source
// event    in   N_CH        stretch-mode trigger (rising edge, synchronous to clk)
// code     in   CODE_W*N_CH blink-code flash count per channel
// led_o    out  N_CH        registered LED drive
// tick_o   out  1           one-cycle strobe per tick
// BEHAVIOUR
// - Reset: prescaler, blink phase, all per-channel counters/FSMs cleared; tick_o=0;
//   led_o = ACTIVE_LOW ? '1 : '0 on the cycle after rst sampled high. Reset overrides everything.
// - Prescaler counts 0..DIV-1, wraps; tick_o=1 in the cycle count==DIV-1. Width $clog2(DIV).
// - Blink phase: tick counter 0..BLINK_T-1, phase toggles on wrap; all blink channels in phase.
// - Modes: 0 STATIC led=level (1 cycle latency); 1 BLINK led=phase; 2 STRETCH; 3 CODE.
// - STRETCH: prev-event register gives rising edge; edge loads cnt=STRETCH_T; led on while cnt!=0;
//   cnt decrements on tick. Edge and tick same cycle: reload wins. Edge at cycle n -> led_o n+2.
//   Retrigger while on reloads full STRETCH_T. Level-high event without new edge does not retrigger.
// - CODE FSM: IDLE -> ON -> OFF -> (ON ... ) -> GAP -> IDLE, transitions only on tick.
//   IDLE: on tick latch code into remaining; code==0 stays IDLE, led off; else -> ON.
//   ON lasts CODE_ON_T ticks, decrement remaining on exit; remaining!=0 -> OFF else -> GAP.
//   OFF lasts CODE_OFF_T ticks -> ON; GAP lasts CODE_GAP_T ticks -> IDLE. led on only in ON.
//   code changes mid-sequence take effect at next IDLE latch.
// - Mode change (registered compare per channel): that channel's FSM forced to IDLE, stretch cnt
//   cleared, same cycle; new mode drives led_o next cycle.
// - Tick-duration counters sized $clog2(max(T)+1); all counters saturate-free by construction.
// - ACTIVE_LOW applied only at the final output register.
// STRUCTURE
// - Package status_led_pkg: MODE_STATIC/BLINK/STRETCH/CODE 2-bit constants, code FSM state enum
//   (S_IDLE,S_ON,S_OFF,S_GAP), helper function for counter width.
// - Top holds prescaler, blink phase, output register; generate loop instantiates
//   status_led_chan (one per channel: edge detect, stretch cnt, code FSM, mode-change detect).
// TESTING (sim params: CLK_HZ=1000,TICK_HZ=100 -> DIV=10, BLINK_T=4, STRETCH_T=3,
//   CODE_ON_T=2, CODE_OFF_T=2, CODE_GAP_T=6, N_CH=2)
// 1. rst high 3 cycles then low -> led_o=0,tick_o=0 during reset; first tick_o 9 cycles after
//    release, then every 10 cycles exactly.
// 2. mode=BLINK both ch -> led_o toggles every 40 cycles, both bits identical every cycle.
// 3. STRETCH, 1-cycle event -> led_o high from edge+2 until 3rd tick after edge; second edge
//    2 ticks later -> on-time extends to 3 ticks from second edge; edge coincident with tick reloads.
// 4. CODE, code=3 -> 3 flashes (20 cycles on / 20 off), 60-cycle gap, repeat; code->1 mid-flash
//    -> current sequence completes 3 flashes, next sequence 1; code=0 -> led stays 0.
// 5. mode CODE->STATIC mid-ON with level=0 -> led_o=0 next cycle; rst asserted mid-stretch ->
//    led_o=0 next cycle, no residual pulse after release.
// 6. ACTIVE_LOW=1 -> reset value led_o=2'b11, every scenario above bitwise inverted.

Source files
------------

// File: rtl/status_led_pkg.sv
// Shared definitions for the status LED driver.
//   MODE_*        per-channel 2-bit mode encodings
//   code_state_t  blink-code sequencer states
//   cnt_width()   bits needed to hold 0..max_val
package status_led_pkg;

   localparam logic [1:0] MODE_STATIC  = 2'd0;
   localparam logic [1:0] MODE_BLINK   = 2'd1;
   localparam logic [1:0] MODE_STRETCH = 2'd2;
   localparam logic [1:0] MODE_CODE    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_GAP  = 2'd3
   } code_state_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/status_led_chan.sv
// One LED channel: event edge detect + pulse stretcher, blink-code sequencer,
// mode-change detect and the per-channel source mux.
//   clk, rst   clock, synchronous active-high reset
//   tick       one-cycle strobe from the shared prescaler
//   phase      shared heartbeat phase
//   mode       channel mode (MODE_*)
//   level      static-mode source
//   evt        stretch trigger (rising edge)
//   code       flash count for blink-code mode
//   led        unregistered LED value (registered in the top)
//
// state  | meaning
// S_IDLE | waiting for a tick to latch the flash count
// S_ON   | flash lit, CODE_ON_T ticks
// S_OFF  | dark between flashes, CODE_OFF_T ticks
// S_GAP  | dark after the last flash, CODE_GAP_T ticks
module status_led_chan
   import status_led_pkg::*;
#(
   parameter int STRETCH_T  = 50,
   parameter int CODE_ON_T  = 200,
   parameter int CODE_OFF_T = 200,
   parameter int CODE_GAP_T = 1000,
   parameter int CODE_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              phase,
   input  logic [1:0]        mode,
   input  logic              level,
   input  logic              evt,
   input  logic [CODE_W-1:0] code,
   output logic              led
);

   localparam int CODE_MAX_T = (CODE_ON_T > CODE_OFF_T) ?
                               ((CODE_ON_T > CODE_GAP_T) ? CODE_ON_T : CODE_GAP_T) :
                               ((CODE_OFF_T > CODE_GAP_T) ? CODE_OFF_T : CODE_GAP_T);
   localparam int TW = cnt_width(CODE_MAX_T);
   localparam int SW = cnt_width(STRETCH_T);

   logic              evt_q;
   logic [1:0]        mode_q;
   logic [SW-1:0]     str_cnt;
   code_state_t       state;
   logic [CODE_W-1:0] remaining;
   logic [TW-1:0]     dur;
   logic              evt_rise;
   logic              mode_chg;

   assign evt_rise = evt & ~evt_q;
   assign mode_chg = (mode != mode_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_q     <= 1'b0;
         mode_q    <= MODE_STATIC;
         str_cnt   <= '0;
         state     <= S_IDLE;
         remaining <= '0;
         dur       <= '0;
      end else begin
         evt_q  <= evt;
         mode_q <= mode;
         if (mode_chg) begin
            str_cnt <= '0;
            state   <= S_IDLE;
            dur     <= '0;
         end else begin
            // A fresh edge reloads even on a tick cycle.
            if (mode == MODE_STRETCH && evt_rise)
               str_cnt <= SW'(STRETCH_T);
            else if (tick && str_cnt != '0)
               str_cnt <= str_cnt - SW'(1);

            if (mode == MODE_CODE && tick) begin
               case (state)
                  S_IDLE: begin
                     remaining <= code;
                     if (code != '0) begin
                        state <= S_ON;
                        dur   <= TW'(CODE_ON_T);
                     end
                  end
                  S_ON: begin
                     if (dur == TW'(1)) begin
                        remaining <= remaining - CODE_W'(1);
                        if (remaining == CODE_W'(1)) begin
                           state <= S_GAP;
                           dur   <= TW'(CODE_GAP_T);
                        end else begin
                           state <= S_OFF;
                           dur   <= TW'(CODE_OFF_T);
                        end
                     end else begin
                        dur <= dur - TW'(1);
                     end
                  end
                  S_OFF: begin
                     if (dur == TW'(1)) begin
                        state <= S_ON;
                        dur   <= TW'(CODE_ON_T);
                     end else begin
                        dur <= dur - TW'(1);
                     end
                  end
                  S_GAP: begin
                     if (dur == TW'(1))
                        state <= S_IDLE;
                     else
                        dur <= dur - TW'(1);
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

   always_comb begin
      led = 1'b0;
      case (mode)
         MODE_STATIC:  led = level;
         MODE_BLINK:   led = phase;
         MODE_STRETCH: led = (str_cnt != '0);
         MODE_CODE:    led = (state == S_ON);
         default:      led = 1'b0;
      endcase
   end

endmodule

// File: rtl/status_led_driver.sv
// Multi-channel board-status LED driver: shared ms-tick prescaler and
// heartbeat phase, one status_led_chan per LED, registered outputs.
//   clk     clock
//   rst     synchronous active-high reset
//   mode    per-channel mode, channel i = mode[2i+1:2i]
//   level   static-mode sources
//   evt     stretch-mode triggers (rising edge)
//   code    per-channel flash counts, channel i = code[CODE_W*i +: CODE_W]
//   led_o   registered LED drive (inverted when ACTIVE_LOW)
//   tick_o  one-cycle strobe per tick
module status_led_driver
   import status_led_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int CLK_HZ     = 125000000,
   parameter int TICK_HZ    = 1000,
   parameter int BLINK_T    = 250,
   parameter int STRETCH_T  = 50,
   parameter int CODE_ON_T  = 200,
   parameter int CODE_OFF_T = 200,
   parameter int CODE_GAP_T = 1000,
   parameter int CODE_W     = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2*N_CH-1:0]        mode,
   input  logic [N_CH-1:0]          level,
   input  logic [N_CH-1:0]          evt,
   input  logic [CODE_W*N_CH-1:0]   code,
   output logic [N_CH-1:0]          led_o,
   output logic                     tick_o
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int BW  = cnt_width(BLINK_T - 1);
   localparam logic [N_CH-1:0] INV = (ACTIVE_LOW != 0) ? '1 : '0;

   if (DIV < 2) begin : g_div_check
      $error("status_led_driver: CLK_HZ/TICK_HZ must be at least 2");
   end

   logic [DW-1:0]   div_cnt;
   logic [BW-1:0]   blink_cnt;
   logic            phase;
   logic [N_CH-1:0] led_next;

   assign tick_o = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         div_cnt <= tick_o ? '0 : div_cnt + DW'(1);
         if (tick_o) begin
            if (blink_cnt == BW'(BLINK_T - 1)) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + BW'(1);
            end
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      status_led_chan #(
         .STRETCH_T  (STRETCH_T),
         .CODE_ON_T  (CODE_ON_T),
         .CODE_OFF_T (CODE_OFF_T),
         .CODE_GAP_T (CODE_GAP_T),
         .CODE_W     (CODE_W)
      ) u_chan (
         .clk   (clk),
         .rst   (rst),
         .tick  (tick_o),
         .phase (phase),
         .mode  (mode[2*i +: 2]),
         .level (level[i]),
         .evt   (evt[i]),
         .code  (code[CODE_W*i +: CODE_W]),
         .led   (led_next[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst)
         led_o <= INV;
      else
         led_o <= led_next ^ INV;
   end

endmodule
